// File: rtl/dispatcher.sv
// Packs 64-bit host words into 256-bit beats for the scanner, tagging each beat
// with cmd/id, byte offset within the buffer, byte valids and end-of-buffer.
module dispatcher (
  input  logic         clk,
  input  logic         reset,
  input  logic         hst_dvld_dpt,
  input  logic [7:0]   hst_cmd_dpt,
  input  logic [23:0]  hst_id_dpt,
  input  logic [63:0]  hst_data_dpt,
  input  logic [7:0]   hst_keep_dpt,
  input  logic         hst_end_dpt,
  output logic         dpt_rdy_hst,
  output logic         dpt_dvld_scn,
  output logic [7:0]   dpt_cmd_scn,
  output logic [23:0]  dpt_id_scn,
  output logic [31:0]  dpt_poff_scn,
  output logic [255:0] dpt_data_scn,
  output logic [31:0]  dpt_bvld_scn,
  output logic         dpt_end_scn,
  input  logic         scn_rdy_dpt
);

  logic [2:0][63:0] acc_data;
  logic [2:0][7:0]  acc_keep;
  logic [1:0]       lane_cnt;
  logic             first;
  logic [31:0]      poff_next;
  logic [7:0]       cmd_q;
  logic [23:0]      id_q;

  logic             out_free;
  logic             completing;
  logic             accept;
  logic             load;
  logic [7:0]       cur_cmd;
  logic [23:0]      cur_id;
  logic [31:0]      cur_poff;
  logic [3:0][63:0] beat_data;
  logic [3:0][7:0]  beat_keep;

  assign out_free    = ~dpt_dvld_scn | scn_rdy_dpt;
  assign completing  = (lane_cnt == 2'd3) | hst_end_dpt;
  assign dpt_rdy_hst = ~reset & (out_free | ((lane_cnt != 2'd3) & ~hst_end_dpt));
  assign accept      = hst_dvld_dpt & dpt_rdy_hst;
  assign load        = accept & completing;

  // The first word of a buffer supplies its tags directly, so a one-word
  // buffer still carries the right cmd/id and starts at offset 0.
  assign cur_cmd  = first ? hst_cmd_dpt : cmd_q;
  assign cur_id   = first ? hst_id_dpt  : id_q;
  assign cur_poff = first ? 32'd0       : poff_next;

  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int i = 0; i < 3; i++) begin
      if (i < int'(lane_cnt)) begin
        beat_data[i] = acc_data[i];
        beat_keep[i] = acc_keep[i];
      end
    end
    beat_data[lane_cnt] = hst_data_dpt;
    beat_keep[lane_cnt] = hst_keep_dpt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_data  <= '0;
      acc_keep  <= '0;
      lane_cnt  <= 2'd0;
      first     <= 1'b1;
      poff_next <= 32'd0;
      cmd_q     <= 8'd0;
      id_q      <= 24'd0;
    end else if (accept) begin
      if (first) begin
        cmd_q <= hst_cmd_dpt;
        id_q  <= hst_id_dpt;
      end
      first <= hst_end_dpt;
      if (completing) begin
        lane_cnt  <= 2'd0;
        poff_next <= cur_poff + 32'd32;
      end else begin
        acc_data[lane_cnt] <= hst_data_dpt;
        acc_keep[lane_cnt] <= hst_keep_dpt;
        lane_cnt           <= lane_cnt + 2'd1;
        if (first) poff_next <= 32'd0;
      end
    end
  end

  // A new beat may replace the one being transferred on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dpt_dvld_scn <= 1'b0;
      dpt_cmd_scn  <= 8'd0;
      dpt_id_scn   <= 24'd0;
      dpt_poff_scn <= 32'd0;
      dpt_data_scn <= 256'd0;
      dpt_bvld_scn <= 32'd0;
      dpt_end_scn  <= 1'b0;
    end else if (load) begin
      dpt_dvld_scn <= 1'b1;
      dpt_cmd_scn  <= cur_cmd;
      dpt_id_scn   <= cur_id;
      dpt_poff_scn <= cur_poff;
      dpt_data_scn <= beat_data;
      dpt_bvld_scn <= beat_keep;
      dpt_end_scn  <= hst_end_dpt;
    end else if (scn_rdy_dpt) begin
      dpt_dvld_scn <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for dispatcher: a reference packer pushes expected beats,
// a monitor pops and compares them on each scanner transfer.
module tb_dispatcher;

  logic         clk = 1'b0;
  logic         reset;
  logic         hst_dvld_dpt;
  logic [7:0]   hst_cmd_dpt;
  logic [23:0]  hst_id_dpt;
  logic [63:0]  hst_data_dpt;
  logic [7:0]   hst_keep_dpt;
  logic         hst_end_dpt;
  logic         dpt_rdy_hst;
  logic         dpt_dvld_scn;
  logic [7:0]   dpt_cmd_scn;
  logic [23:0]  dpt_id_scn;
  logic [31:0]  dpt_poff_scn;
  logic [255:0] dpt_data_scn;
  logic [31:0]  dpt_bvld_scn;
  logic         dpt_end_scn;
  logic         scn_rdy_dpt;

  typedef struct packed {
    logic [7:0]   cmd;
    logic [23:0]  id;
    logic [31:0]  poff;
    logic [255:0] data;
    logic [31:0]  bvld;
    logic         end_f;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int beats_seen = 0;

  logic [3:0][63:0] m_data;
  logic [3:0][7:0]  m_keep;
  int               m_cnt;
  bit               m_first;
  logic [31:0]      m_poff;
  logic [7:0]       m_cmd;
  logic [23:0]      m_id;

  dispatcher dut (
    .clk          (clk),
    .reset        (reset),
    .hst_dvld_dpt (hst_dvld_dpt),
    .hst_cmd_dpt  (hst_cmd_dpt),
    .hst_id_dpt   (hst_id_dpt),
    .hst_data_dpt (hst_data_dpt),
    .hst_keep_dpt (hst_keep_dpt),
    .hst_end_dpt  (hst_end_dpt),
    .dpt_rdy_hst  (dpt_rdy_hst),
    .dpt_dvld_scn (dpt_dvld_scn),
    .dpt_cmd_scn  (dpt_cmd_scn),
    .dpt_id_scn   (dpt_id_scn),
    .dpt_poff_scn (dpt_poff_scn),
    .dpt_data_scn (dpt_data_scn),
    .dpt_bvld_scn (dpt_bvld_scn),
    .dpt_end_scn  (dpt_end_scn),
    .scn_rdy_dpt  (scn_rdy_dpt)
  );

  always #5 clk = ~clk;

  function automatic beat_t observed();
    return {dpt_cmd_scn, dpt_id_scn, dpt_poff_scn, dpt_data_scn, dpt_bvld_scn, dpt_end_scn};
  endfunction

  task automatic check_output(input string tag, input logic [352:0] obs, input logic [352:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_first = 1'b1;
    m_poff  = 32'd0;
    exp_q.delete();
  endtask

  // Reference packer, advanced once per accepted host word.
  task automatic model_accept(input logic [7:0] cmd, input logic [23:0] id,
                              input logic [63:0] data, input logic [7:0] keep, input logic end_w);
    beat_t b;
    if (m_first) begin
      m_cmd  = cmd;
      m_id   = id;
      m_poff = 32'd0;
    end
    m_data[m_cnt] = data;
    m_keep[m_cnt] = keep;
    if (m_cnt == 3 || end_w) begin
      b = '0;
      for (int i = 0; i <= m_cnt; i++) begin
        b.data[64*i +: 64] = m_data[i];
        b.bvld[8*i +: 8]   = m_keep[i];
      end
      b.cmd   = m_cmd;
      b.id    = m_id;
      b.poff  = m_poff;
      b.end_f = end_w;
      exp_q.push_back(b);
      m_poff = m_poff + 32'd32;
      m_cnt  = 0;
    end else begin
      m_cnt++;
    end
    m_first = end_w;
  endtask

  task automatic apply_stimulus(input logic [7:0] cmd, input logic [23:0] id,
                                input logic [63:0] data, input logic [7:0] keep, input logic end_w);
    bit done = 1'b0;
    hst_dvld_dpt = 1'b1;
    hst_cmd_dpt  = cmd;
    hst_id_dpt   = id;
    hst_data_dpt = data;
    hst_keep_dpt = keep;
    hst_end_dpt  = end_w;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (dpt_rdy_hst) begin
        model_accept(cmd, id, data, keep, end_w);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    hst_dvld_dpt = 1'b0;
    hst_end_dpt  = 1'b0;
    check_output("word_accepted", 353'(done), 353'(1));
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check_output("drain", 353'(exp_q.size()), 353'(0));
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_output("rst_outputs", 353'(observed()), 353'(0));
    check_output("rst_dvld", 353'(dpt_dvld_scn), 353'(0));
    check_output("rst_rdy", 353'(dpt_rdy_hst), 353'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_output("rdy_after_rst", 353'(dpt_rdy_hst), 353'(1));
  endtask

  // Scoreboard side: every transfer must match the oldest expected beat.
  always @(negedge clk) begin
    if (!reset && dpt_dvld_scn && scn_rdy_dpt) begin
      beats_seen++;
      check_output("beat_expected", 353'(exp_q.size() != 0), 353'(1));
      if (exp_q.size() != 0) check_output("beat", 353'(observed()), 353'(exp_q.pop_front()));
    end
  end

  initial begin
    beat_t snap;
    int base;
    reset = 1'b1;
    hst_dvld_dpt = 1'b0;
    hst_cmd_dpt = '0;
    hst_id_dpt = '0;
    hst_data_dpt = '0;
    hst_keep_dpt = '0;
    hst_end_dpt = 1'b0;
    scn_rdy_dpt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("init_outputs", 353'(observed()), 353'(0));
    check_output("init_rdy", 353'(dpt_rdy_hst), 353'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] async reset with pending beat");
    for (int i = 0; i < 4; i++) apply_stimulus(8'h11, 24'h000011, 64'(i + 50), 8'hFF, 1'b0);
    check_output("pending_dvld", 353'(dpt_dvld_scn), 353'(1));
    pulse_reset();

    $display("[TB] full buffer");
    scn_rdy_dpt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(8'h02, 24'hABCDEF, 64'(i), 8'hFF, 1'(i == 7));
      if (i == 3) begin
        check_output("full_b1_dvld", 353'(dpt_dvld_scn), 353'(1));
        check_output("full_b1_poff", 353'(dpt_poff_scn), 353'(0));
        check_output("full_b1_data", 353'(dpt_data_scn),
                     353'({64'd3, 64'd2, 64'd1, 64'd0}));
        check_output("full_b1_bvld", 353'(dpt_bvld_scn), 353'(32'hFFFF_FFFF));
        check_output("full_b1_end", 353'(dpt_end_scn), 353'(0));
      end
    end
    check_output("full_b2_poff", 353'(dpt_poff_scn), 353'(32));
    check_output("full_b2_end", 353'(dpt_end_scn), 353'(1));
    wait_drain();

    $display("[TB] partial end");
    for (int i = 0; i < 5; i++)
      apply_stimulus(8'h04, 24'h000444, 64'(i), (i == 4) ? 8'h0F : 8'hFF, 1'(i == 4));
    check_output("part_poff", 353'(dpt_poff_scn), 353'(32));
    check_output("part_data", 353'(dpt_data_scn), 353'(256'(64'd4)));
    check_output("part_bvld", 353'(dpt_bvld_scn), 353'(32'h0000_000F));
    check_output("part_end", 353'(dpt_end_scn), 353'(1));
    wait_drain();

    $display("[TB] backpressure");
    scn_rdy_dpt = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(8'h05, 24'h000055, 64'(100 + i), 8'hFF, 1'b0);
    snap = observed();
    for (int i = 4; i < 7; i++) apply_stimulus(8'h05, 24'h000055, 64'(100 + i), 8'hFF, 1'b0);
    hst_dvld_dpt = 1'b1;
    hst_data_dpt = 64'd107;
    hst_end_dpt  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_output("bp_rdy_low", 353'(dpt_rdy_hst), 353'(0));
      check_output("bp_stable", 353'(observed()), 353'(snap));
      check_output("bp_dvld", 353'(dpt_dvld_scn), 353'(1));
    end
    @(posedge clk);
    #1;
    scn_rdy_dpt = 1'b1;
    apply_stimulus(8'h05, 24'h000055, 64'd107, 8'hFF, 1'b1);
    check_output("bp_swap_dvld", 353'(dpt_dvld_scn), 353'(1));
    check_output("bp_swap_poff", 353'(dpt_poff_scn), 353'(32));
    wait_drain();

    $display("[TB] back-to-back buffers");
    for (int i = 0; i < 6; i++) apply_stimulus(8'h01, 24'd1, 64'(300 + i), 8'hFF, 1'(i == 5));
    apply_stimulus(8'h03, 24'd2, 64'd400, 8'hFF, 1'b0);
    for (int i = 1; i < 4; i++) apply_stimulus(8'hEE, 24'h123456, 64'(400 + i), 8'hFF, 1'(i == 3));
    check_output("b2b_cmd", 353'(dpt_cmd_scn), 353'(8'h03));
    check_output("b2b_id", 353'(dpt_id_scn), 353'(24'd2));
    check_output("b2b_poff", 353'(dpt_poff_scn), 353'(0));
    wait_drain();

    $display("[TB] reset mid-buffer");
    for (int i = 0; i < 2; i++) apply_stimulus(8'h07, 24'd77, 64'(500 + i), 8'hFF, 1'b0);
    pulse_reset();
    base = beats_seen;
    for (int i = 0; i < 4; i++) apply_stimulus(8'h08, 24'd88, 64'(600 + i), 8'hFF, 1'(i == 3));
    check_output("mid_poff", 353'(dpt_poff_scn), 353'(0));
    check_output("mid_end", 353'(dpt_end_scn), 353'(1));
    wait_drain();
    check_output("mid_beat_count", 353'(beats_seen - base), 353'(1));

    $display("[TB] zero-keep end word and end-word backpressure");
    scn_rdy_dpt = 1'b0;
    apply_stimulus(8'h09, 24'd99, 64'hDEAD, 8'h00, 1'b1);
    check_output("zk_dvld", 353'(dpt_dvld_scn), 353'(1));
    check_output("zk_bvld", 353'(dpt_bvld_scn), 353'(0));
    check_output("zk_data", 353'(dpt_data_scn), 353'(256'(64'hDEAD)));
    hst_dvld_dpt = 1'b1;
    hst_end_dpt  = 1'b1;
    @(negedge clk);
    check_output("end_rdy_low", 353'(dpt_rdy_hst), 353'(0));
    @(posedge clk);
    #1;
    scn_rdy_dpt = 1'b1;
    apply_stimulus(8'h0A, 24'd10, 64'hBEEF, 8'h3C, 1'b1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
